// File: rtl/sprite_dma_arbiter.sv
// Sprite DMA arbiter: a CPU write to TRIG_ADDR halts the CPU and copies one 256-byte page to DEST_ADDR.
// Optional completion interrupt is built only when SPRITE_DMA_IRQ_EN is defined.
module sprite_dma_arbiter #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  input  logic [7:0]  mem_idata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_odata,
  output logic        mem_rw,
  output logic        busy,
  output logic        dma_irq
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0] state_r;
  logic [7:0] page_r;
  logic [7:0] index_r;
  logic [7:0] data_r;
  logic       trig_s;
  logic       last_s;

  assign trig_s = (cpu_rw == 1'b0) && (cpu_addr == TRIG_ADDR);
  assign last_s = (index_r == 8'hFF);

  // Transfer sequencer: page/index source pointer, one read then one write per byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      page_r  <= 8'h00;
      index_r <= 8'h00;
      data_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            page_r  <= cpu_odata;
            index_r <= 8'h00;
            state_r <= ALIGN;
          end
        end
        ALIGN: state_r <= READ;
        READ: begin
          data_r  <= mem_idata;
          state_r <= WRITE;
        end
        WRITE: begin
          // index wraps within the page; the page byte is never incremented
          index_r <= index_r + 8'h01;
          state_r <= last_s ? IDLE : READ;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Bus mux: the CPU owns memory in IDLE, the DMA engine otherwise.
  always_comb begin
    cpu_rdy   = 1'b1;
    busy      = 1'b0;
    mem_addr  = cpu_addr;
    mem_odata = cpu_odata;
    mem_rw    = cpu_rw;
    case (state_r)
      IDLE: begin
        cpu_rdy   = 1'b1;
        busy      = 1'b0;
        mem_addr  = cpu_addr;
        mem_odata = cpu_odata;
        mem_rw    = cpu_rw;
      end
      ALIGN, READ: begin
        cpu_rdy   = 1'b0;
        busy      = 1'b1;
        mem_addr  = {page_r, index_r};
        mem_odata = data_r;
        mem_rw    = 1'b1;
      end
      WRITE: begin
        cpu_rdy   = 1'b0;
        busy      = 1'b1;
        mem_addr  = DEST_ADDR;
        mem_odata = data_r;
        mem_rw    = 1'b0;
      end
      default: begin
        cpu_rdy   = 1'b1;
        busy      = 1'b0;
        mem_addr  = cpu_addr;
        mem_odata = cpu_odata;
        mem_rw    = cpu_rw;
      end
    endcase
  end

`ifdef SPRITE_DMA_IRQ_EN
  logic irq_r;

  // Completion flag: set leaving the final write, cleared by the next trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else if ((state_r == IDLE) && trig_s) begin
      irq_r <= 1'b0;
    end else if ((state_r == WRITE) && last_s) begin
      irq_r <= 1'b1;
    end
  end

  assign dma_irq = irq_r;
`else
  assign dma_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_dma_arbiter.sv
// Self-checking bench for sprite_dma_arbiter: scoreboard of expected DMA writes plus directed bus checks.
module tb_sprite_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [7:0]  mem_idata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_odata;
  logic        mem_rw;
  logic        busy;
  logic        dma_irq;

  int  n_checks = 0;
  int  n_errors = 0;
  int  halt_cnt = 0;
  int  post_writes = 0;
  bit  scramble = 1'b0;
  bit  after_abort = 1'b0;
  bit  saw_zero = 1'b0;
  logic [15:0] last_read = 16'h0000;
  logic [7:0]  exp_q [$];

`ifdef SPRITE_DMA_IRQ_EN
  localparam logic IRQ_DONE = 1'b1;
`else
  localparam logic IRQ_DONE = 1'b0;
`endif

  sprite_dma_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_odata (cpu_odata),
    .cpu_rw    (cpu_rw),
    .cpu_rdy   (cpu_rdy),
    .mem_idata (mem_idata),
    .mem_addr  (mem_addr),
    .mem_odata (mem_odata),
    .mem_rw    (mem_rw),
    .busy      (busy),
    .dma_irq   (dma_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input bit scr);
    return scr ? (a[7:0] ^ a[15:8] ^ 8'h5A) : a[7:0];
  endfunction

  // Asynchronous-read memory model
  assign mem_idata = mem_byte(mem_addr, scramble);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: count halted cycles, score DMA writes, track source reads
  always @(negedge clk) begin
    if (!cpu_rdy) halt_cnt++;
    if (busy && mem_rw) begin
      last_read = mem_addr;
      if (mem_addr == 16'h0000) saw_zero = 1'b1;
    end
    if (!mem_rw && mem_addr == 16'h2004) begin
      if (after_abort) begin
        post_writes++;
      end else if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'd1, 32'd0);
      end else begin
        check_eq("dma_wdata", {24'h0, mem_odata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Drives a trigger write and queues the 256 expected bytes; trigger stays on the bus on return.
  task automatic start_dma(input logic [7:0] pg, input bit scr);
    scramble = scr;
    for (int i = 0; i < 256; i++) exp_q.push_back(mem_byte({pg, i[7:0]}, scr));
    cpu_addr  = 16'h4014;
    cpu_odata = pg;
    cpu_rw    = 1'b0;
    #1;
    check_eq("trig_passthru_addr", {16'h0, mem_addr}, {16'h0, 16'h4014});
    check_eq("trig_passthru_data", {24'h0, mem_odata}, {24'h0, pg});
    check_eq("trig_passthru_rw", {31'h0, mem_rw}, 32'd0);
    @(posedge clk);
    halt_cnt = 0;
    #1;
  endtask

  task automatic release_bus();
    cpu_addr  = 16'h0000;
    cpu_odata = 8'h00;
    cpu_rw    = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!cpu_rdy && n < 700) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, {31'h0, cpu_rdy}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    release_bus();
    #3;
    check_eq("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'd1);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_irq", {31'h0, dma_irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_addr", {16'h0, mem_addr}, 32'h0000);
    check_eq("idle_rw", {31'h0, mem_rw}, 32'd1);
    check_eq("idle_rdy", {31'h0, cpu_rdy}, 32'd1);
    check_eq("idle_busy", {31'h0, busy}, 32'd0);

    // Page 2, trigger held during ALIGN/READ must be ignored
    start_dma(8'h02, 1'b1);
    cpu_odata = 8'h77;
    #1;
    check_eq("align_rdy", {31'h0, cpu_rdy}, 32'd0);
    check_eq("align_busy", {31'h0, busy}, 32'd1);
    check_eq("align_addr", {16'h0, mem_addr}, 32'h0200);
    check_eq("align_rw", {31'h0, mem_rw}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("read_addr", {16'h0, mem_addr}, 32'h0200);
    check_eq("read_rw", {31'h0, mem_rw}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("write_addr", {16'h0, mem_addr}, 32'h2004);
    check_eq("write_rw", {31'h0, mem_rw}, 32'd0);
    check_eq("write_data", {24'h0, mem_odata}, {24'h0, mem_byte(16'h0200, 1'b1)});
    release_bus();
    wait_idle("done_p02");
    check_eq("halt_p02", halt_cnt, 32'd513);
    check_eq("q_empty_p02", exp_q.size(), 32'd0);
    check_eq("irq_p02", {31'h0, dma_irq}, {31'h0, IRQ_DONE});

    // Page 3, memory byte = low address
    start_dma(8'h03, 1'b0);
    check_eq("irq_clear", {31'h0, dma_irq}, 32'd0);
    release_bus();
    wait_idle("done_p03");
    check_eq("halt_p03", halt_cnt, 32'd513);
    check_eq("q_empty_p03", exp_q.size(), 32'd0);
    check_eq("irq_p03", {31'h0, dma_irq}, {31'h0, IRQ_DONE});

    // Page FF must not wrap into page 0
    saw_zero = 1'b0;
    start_dma(8'hFF, 1'b1);
    release_bus();
    wait_idle("done_pff");
    check_eq("last_read_pff", {16'h0, last_read}, 32'hFFFF);
    check_eq("no_wrap_pff", {31'h0, saw_zero}, 32'd0);
    check_eq("busy_pff", {31'h0, busy}, 32'd0);
    check_eq("q_empty_pff", exp_q.size(), 32'd0);

    // Abort with reset at transfer cycle 100
    start_dma(8'h05, 1'b0);
    release_bus();
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    after_abort = 1'b1;
    exp_q.delete();
    #1;
    check_eq("abort_rdy", {31'h0, cpu_rdy}, 32'd1);
    check_eq("abort_busy", {31'h0, busy}, 32'd0);
    check_eq("abort_irq", {31'h0, dma_irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort_no_write", post_writes, 32'd0);
    check_eq("abort_idle_rdy", {31'h0, cpu_rdy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_dma_arbiter.md
SPRITE_DMA_ARBITER -- requirements
Module: sprite_dma_arbiter

Interface
REQ-001 SHALL have parameter TRIG_ADDR, default 16'h4014: CPU write address that starts a transfer.
REQ-002 SHALL have parameter DEST_ADDR, default 16'h2004: fixed write target of every DMA byte.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_addr  input  16  CPU address bus.
REQ-006 SHALL have port cpu_odata  input  8  CPU write data.
REQ-007 SHALL have port cpu_rw  input  1  CPU direction, 1=read, 0=write.
REQ-008 SHALL have port cpu_rdy  output  1  1=CPU may run, 0=CPU halted.
REQ-009 SHALL have port mem_idata  input  8  memory read data.
REQ-010 SHALL have port mem_addr  output  16  arbitrated memory address.
REQ-011 SHALL have port mem_odata  output  8  arbitrated memory write data.
REQ-012 SHALL have port mem_rw  output  1  arbitrated direction, 1=read.
REQ-013 SHALL have port busy  output  1  1 while a transfer is in progress.
REQ-014 SHALL have port dma_irq  output  1  completion interrupt (see Configuration).

Function
REQ-015 SHALL implement states IDLE, ALIGN, READ, WRITE.
REQ-016 In IDLE: mem_addr=cpu_addr, mem_odata=cpu_odata, mem_rw=cpu_rw, cpu_rdy=1, busy=0; the mux is combinational.
REQ-017 In IDLE, a rising edge with cpu_rw=0 and cpu_addr=TRIG_ADDR SHALL latch page<=cpu_odata, clear index<=8'h00, and go to ALIGN; that write also reaches memory unchanged.
REQ-018 In ALIGN, READ and WRITE: cpu_rdy=0, busy=1, and the CPU bus inputs are ignored, including further trigger writes.
REQ-019 ALIGN SHALL last exactly one cycle with mem_rw=1 and mem_addr={page,index}, then go to READ.
REQ-020 READ: mem_addr={page,index}, mem_rw=1; data<=mem_idata at the closing edge; next state WRITE.
REQ-021 WRITE: mem_addr=DEST_ADDR, mem_odata=data, mem_rw=0; at the closing edge index<=index+1 (8-bit).
REQ-022 After WRITE, go to READ if index was not 8'hFF, else go to IDLE.
REQ-023 A transfer SHALL copy exactly 256 bytes in 1+512 = 513 halted cycles; cpu_rdy returns to 1 on the cycle after the last WRITE.
REQ-024 The source address SHALL never carry into the next page; page 8'hFF reads 16'hFF00..16'hFFFF.
REQ-025 In non-IDLE states, mem_odata SHALL equal the data register.

Reset
REQ-026 While reset=1, independent of clk: state=IDLE, page=0, index=0, data=0, dma_irq=0; outputs follow REQ-016.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer at once with no further DMA write, and cpu_rdy=1 while reset is held.

Configuration
REQ-028 Macro SPRITE_DMA_IRQ_EN: when defined, dma_irq SHALL set to 1 on the edge that leaves the final WRITE, hold until the next trigger write, and clear on that trigger edge.
REQ-029 Without SPRITE_DMA_IRQ_EN, dma_irq SHALL be constant 0 and no irq flop SHALL exist; all other behaviour is identical.

Verification
REQ-030 Reset release, CPU reads 16'h0000 -> mem_addr=16'h0000, mem_rw=1, cpu_rdy=1, busy=0.
REQ-031 CPU writes 8'h02 to 16'h4014 -> next cycle ALIGN with cpu_rdy=0 -> cycle 2 mem_addr=16'h0200 read -> cycle 3 mem_addr=16'h2004, rw=0, odata=mem[16'h0200].
REQ-032 Full transfer from page 8'h03 with memory byte = low address -> 256 writes to 16'h2004 with data 8'h00..8'hFF in order; cpu_rdy low for exactly 513 cycles.
REQ-033 Page 8'hFF -> last read address is 16'hFFFF, never 16'h0000; the transfer then returns to IDLE.
REQ-034 Reset pulsed at transfer cycle 100 -> immediate IDLE, cpu_rdy=1, and no write to 16'h2004 after the pulse.
REQ-035 With SPRITE_DMA_IRQ_EN -> dma_irq=1 after REQ-032 completes and returns to 0 on the next write to 16'h4014; without the macro, dma_irq stays 0 throughout.
